// File: rtl/poly_pkg.sv
// Shared types and constants for the polynomial inverse solver:
// FSM state encoding, ALU opcodes, operand selects and the per-state
// ALU control lookup.
package poly_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [4:0] {
    S_LOAD_A      = 5'd0,
    S_LOAD_A_WAIT = 5'd1,
    S_LOAD_B      = 5'd2,
    S_LOAD_B_WAIT = 5'd3,
    S_LOAD_C      = 5'd4,
    S_LOAD_C_WAIT = 5'd5,
    S_LOAD_Y      = 5'd6,
    S_LOAD_Y_WAIT = 5'd7,
    S_INIT        = 5'd8,
    S_EVAL_0      = 5'd9,
    S_EVAL_1      = 5'd10,
    S_EVAL_2      = 5'd11,
    S_EVAL_3      = 5'd12,
    S_EVAL_4      = 5'd13,
    S_CMP         = 5'd14,
    S_DONE        = 5'd15,
    S_DONE_WAIT   = 5'd16
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam logic [2:0] SEL_A = 3'd0;
  localparam logic [2:0] SEL_B = 3'd1;
  localparam logic [2:0] SEL_C = 3'd2;
  localparam logic [2:0] SEL_X = 3'd3;
  localparam logic [2:0] SEL_T = 3'd4;
  localparam logic [2:0] SEL_U = 3'd5;

  typedef struct packed {
    logic       op;
    logic [2:0] sel_l;
    logic [2:0] sel_r;
  } alu_ctl_t;

  // One ALU operation per evaluation state; f(x) = a*x + (b*x)*x + c
  function automatic alu_ctl_t alu_ctl_for(state_t s);
    alu_ctl_t ctl;
    ctl = '{op: OP_ADD, sel_l: SEL_A, sel_r: SEL_A};
    case (s)
      S_EVAL_0: ctl = '{op: OP_MUL, sel_l: SEL_A, sel_r: SEL_X};
      S_EVAL_1: ctl = '{op: OP_MUL, sel_l: SEL_B, sel_r: SEL_X};
      S_EVAL_2: ctl = '{op: OP_MUL, sel_l: SEL_U, sel_r: SEL_X};
      S_EVAL_3: ctl = '{op: OP_ADD, sel_l: SEL_T, sel_r: SEL_U};
      S_EVAL_4: ctl = '{op: OP_ADD, sel_l: SEL_T, sel_r: SEL_C};
      default:  ctl = '{op: OP_ADD, sel_l: SEL_A, sel_r: SEL_A};
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/poly_alu.sv
// Shared datapath ALU: two operand muxes feeding a WIDTH-bit add or
// multiply. Results are truncated to WIDTH bits (mod 2^WIDTH).
module poly_alu
  import poly_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             op,
  input  logic [2:0]       sel_l,
  input  logic [2:0]       sel_r,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] opnd_l;
  logic [WIDTH-1:0] opnd_r;

  // Operand selection and the single arithmetic operation
  always_comb begin
    opnd_l = '0;
    opnd_r = '0;
    case (sel_l)
      SEL_A:   opnd_l = a;
      SEL_B:   opnd_l = b;
      SEL_C:   opnd_l = c;
      SEL_X:   opnd_l = x;
      SEL_T:   opnd_l = t;
      SEL_U:   opnd_l = u;
      default: opnd_l = '0;
    endcase
    case (sel_r)
      SEL_A:   opnd_r = a;
      SEL_B:   opnd_r = b;
      SEL_C:   opnd_r = c;
      SEL_X:   opnd_r = x;
      SEL_T:   opnd_r = t;
      SEL_U:   opnd_r = u;
      default: opnd_r = '0;
    endcase
    result = (op == OP_MUL) ? opnd_l * opnd_r : opnd_l + opnd_r;
  end

endmodule

// File: rtl/poly_inverse_solver.sv
// Searches x = 0 .. 2^WIDTH-1 for the first x with a*x + b*x^2 + c == y
// (mod 2^WIDTH). Operands are entered with a go/data_in button protocol.
//
// state         | meaning
// S_LOAD_A..Y   | operand register tracks data_in; go freezes it
// S_LOAD_*_WAIT | wait for go release
// S_INIT        | clear candidate x
// S_EVAL_0..4   | one ALU step each: t=a*x, u=b*x, u=u*x, t=t+u, t=t+c
// S_CMP         | compare f(x) to y, finish or advance x
// S_DONE        | result valid, wait for go press
// S_DONE_WAIT   | wait for go release, then back to S_LOAD_A
module poly_inverse_solver
  import poly_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] x_result,
  output logic             found,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] X_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a, b, c, y, x, t, u;
  logic [WIDTH-1:0] alu_y;
  alu_ctl_t         alu_ctl;
  logic             hit;
  logic             last_x;

  assign alu_ctl = alu_ctl_for(state);
  assign hit     = (t == y);
  assign last_x  = (x == X_MAX);

  poly_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (alu_ctl.op),
    .sel_l  (alu_ctl.sel_l),
    .sel_r  (alu_ctl.sel_r),
    .a      (a),
    .b      (b),
    .c      (c),
    .x      (x),
    .t      (t),
    .u      (u),
    .result (alu_y)
  );

  // Next-state decode; go only matters in load and done states
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD_A:      if (go)  state_nxt = S_LOAD_A_WAIT;
      S_LOAD_A_WAIT: if (!go) state_nxt = S_LOAD_B;
      S_LOAD_B:      if (go)  state_nxt = S_LOAD_B_WAIT;
      S_LOAD_B_WAIT: if (!go) state_nxt = S_LOAD_C;
      S_LOAD_C:      if (go)  state_nxt = S_LOAD_C_WAIT;
      S_LOAD_C_WAIT: if (!go) state_nxt = S_LOAD_Y;
      S_LOAD_Y:      if (go)  state_nxt = S_LOAD_Y_WAIT;
      S_LOAD_Y_WAIT: if (!go) state_nxt = S_INIT;
      S_INIT:        state_nxt = S_EVAL_0;
      S_EVAL_0:      state_nxt = S_EVAL_1;
      S_EVAL_1:      state_nxt = S_EVAL_2;
      S_EVAL_2:      state_nxt = S_EVAL_3;
      S_EVAL_3:      state_nxt = S_EVAL_4;
      S_EVAL_4:      state_nxt = S_CMP;
      S_CMP:         state_nxt = (hit || last_x) ? S_DONE : S_EVAL_0;
      S_DONE:        if (go)  state_nxt = S_DONE_WAIT;
      S_DONE_WAIT:   if (!go) state_nxt = S_LOAD_A;
      default:       state_nxt = S_LOAD_A;
    endcase
  end

  // Control FSM with registered busy/done derived from the next state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_LOAD_A;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt inside {S_INIT, S_EVAL_0, S_EVAL_1, S_EVAL_2,
                                  S_EVAL_3, S_EVAL_4, S_CMP});
      done  <= (state_nxt inside {S_DONE, S_DONE_WAIT});
    end
  end

  // Datapath registers; x is tested for its last value before incrementing
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a        <= '0;
      b        <= '0;
      c        <= '0;
      y        <= '0;
      x        <= '0;
      t        <= '0;
      u        <= '0;
      x_result <= '0;
      found    <= 1'b0;
    end else begin
      case (state)
        S_LOAD_A: a <= data_in;
        S_LOAD_B: b <= data_in;
        S_LOAD_C: c <= data_in;
        S_LOAD_Y: y <= data_in;
        S_INIT:   x <= '0;
        S_EVAL_0: t <= alu_y;
        S_EVAL_1: u <= alu_y;
        S_EVAL_2: u <= alu_y;
        S_EVAL_3: t <= alu_y;
        S_EVAL_4: t <= alu_y;
        S_CMP: begin
          if (hit) begin
            x_result <= x;
            found    <= 1'b1;
          end else if (last_x) begin
            x_result <= '0;
            found    <= 1'b0;
          end else begin
            x <= x + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_inverse_solver.sv
// Scoreboard bench for poly_inverse_solver: each search pushes its
// hand-computed result and done latency; a monitor pops on done rising.
module tb_poly_inverse_solver;
  import poly_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         go = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] x_result;
  logic         found;
  logic         done;
  logic         busy;

  always #5 clk = ~clk;

  poly_inverse_solver #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .go       (go),
    .data_in  (data_in),
    .x_result (x_result),
    .found    (found),
    .done     (done),
    .busy     (busy)
  );

  typedef struct {
    logic [W-1:0] x;
    logic         f;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: latency counted from busy rising (S_INIT entry) to done rising
  initial begin
    logic busy_q;
    logic done_q;
    int   lat;
    exp_t e;
    busy_q = 1'b0;
    done_q = 1'b0;
    lat    = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && busy_q !== 1'b1) lat = 0;
      else lat++;
      if (done === 1'b1 && done_q !== 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no result pending");
        end else begin
          e = sb.pop_front();
          check("x_result", 32'(x_result), 32'(e.x));
          check("found", 32'(found), 32'(e.f));
          check("done_latency", 32'(lat), 32'(e.lat));
        end
      end
      busy_q = busy;
      done_q = done;
    end
  end

  task automatic press(input logic [W-1:0] v);
    @(negedge clk);
    data_in = v;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_all(input logic [W-1:0] a, b, c, y);
    press(a);
    press(b);
    press(c);
    press(y);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run_case(input logic [W-1:0] a, b, c, y,
                          input logic [W-1:0] ex, input logic ef, input int elat);
    exp_t e;
    e.x = ex;
    e.f = ef;
    e.lat = elat;
    sb.push_back(e);
    load_all(a, b, c, y);
    wait_done(2000);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dut.state), 32'(S_LOAD_A));
    check("rst_x_result", 32'(x_result), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // f(x)=x, y=5 -> x=5, latency 1+6*6
    run_case(8'd1, 8'd0, 8'd0, 8'd5, 8'd5, 1'b1, 37);
    press(8'd0);
    // f(x)=x^2, y=9 -> first root 3
    run_case(8'd0, 8'd1, 8'd0, 8'd9, 8'd3, 1'b1, 25);
    press(8'd0);
    // x+10 = 4 mod 256 -> 250
    run_case(8'd1, 8'd0, 8'd10, 8'd4, 8'd250, 1'b1, 1 + 6 * 251);
    press(8'd0);
    // 2x+1 always odd -> no match, x stops at 255
    run_case(8'd2, 8'd0, 8'd1, 8'd4, 8'd0, 1'b0, 1537);
    check("nomatch_x_stop", 32'(dut.x), 32'd255);
    check("nomatch_busy", 32'(busy), 32'd0);
    press(8'd0);
    // x + x^2 + 3 = 3 -> first candidate
    run_case(8'd1, 8'd1, 8'd3, 8'd3, 8'd0, 1'b1, 7);
    press(8'd0);
    check("after_done_state", 32'(dut.state), 32'(S_LOAD_A));
    check("after_done_x_result", 32'(x_result), 32'd0);
    check("after_done_found", 32'(found), 32'd1);
    check("after_done_done", 32'(done), 32'd0);

    // go during search is ignored; reset aborts the search
    load_all(8'd2, 8'd0, 8'd1, 8'd4);
    repeat (49) @(negedge clk);
    go = 1'b1;
    repeat (3) @(negedge clk);
    go = 1'b0;
    repeat (10) @(negedge clk);
    check("go_ignored_busy", 32'(busy), 32'd1);
    check("go_ignored_done", 32'(done), 32'd0);
    repeat (137) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(dut.state), 32'(S_LOAD_A));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_found", 32'(found), 32'd0);
    check("midrst_x_result", 32'(x_result), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
